// File: rtl/ts_pkg.sv
// Shared constants and types for the time-sync buffer port arbiter.
package ts_pkg;

    localparam int TS_NUM_REQ     = 4;
    localparam int TS_BUFF_ADDR_W = 12;
    localparam int TS_SAMPLE_W    = 8;
    localparam int TS_ID_W        = 2;

    localparam logic [TS_ID_W-1:0] TS_REQ_CAPTURE = 2'd0;
    localparam logic [TS_ID_W-1:0] TS_REQ_PWIN    = 2'd1;
    localparam logic [TS_ID_W-1:0] TS_REQ_RWIN    = 2'd2;
    localparam logic [TS_ID_W-1:0] TS_REQ_CPREM   = 2'd3;

    typedef struct packed {
        logic               valid;
        logic               rd;
        logic [TS_ID_W-1:0] id;
    } ts_tag_t;

endpackage

// File: rtl/ts_arb_pick.sv
// Combinational one-hot grant pick: a holding owner wins outright, otherwise the
// first requester found searching upward (with wrap) from the start index.
module ts_arb_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start,
    input  logic               lock_hold,
    input  logic [ID_W-1:0]    owner,
    output logic [NUM_REQ-1:0] gnt
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        if (lock_hold) begin
            gnt[owner] = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = ID_W'((int'(start) + k) % NUM_REQ);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ts_bram_port_arbiter.sv
// Shares one single-port buffer BRAM among the time-sync stages with burst locking
// and tagged read return. Define TS_ARB_ROUND_ROBIN_EN for round-robin arbitration.
import ts_pkg::*;

module ts_bram_port_arbiter #(
    parameter int NUM_REQ = TS_NUM_REQ,
    parameter int ADDR_W  = TS_BUFF_ADDR_W,
    parameter int DATA_W  = TS_SAMPLE_W,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      bram_en,
    output logic                      bram_we,
    output logic [ADDR_W-1:0]         bram_addr,
    output logic [DATA_W-1:0]         bram_di,
    input  logic [DATA_W-1:0]         bram_dout
);

    localparam int ID_W = TS_ID_W;

    logic              owner_valid;
    logic [ID_W-1:0]   owner_id;
    logic              lock_hold;
    logic [ID_W-1:0]   start;
    logic              accept;
    logic [ID_W-1:0]   acc_id;
    logic              acc_we;
    logic              acc_lock;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    ts_tag_t           tag_pipe [RD_LAT+1];
    ts_tag_t           tag_out;

    assign lock_hold = owner_valid && req[owner_id] && req_lock[owner_id];

`ifdef TS_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr;

    // Locked continuation beats do not move the pointer, so a burst does not skew fairness.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept && !lock_hold) begin
            rr_ptr <= (acc_id == ID_W'(NUM_REQ-1)) ? '0 : acc_id + 1'b1;
        end
    end

    assign start = rr_ptr;
`else
    assign start = '0;
`endif

    ts_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req       (req),
        .start     (start),
        .lock_hold (lock_hold),
        .owner     (owner_id),
        .gnt       (gnt)
    );

    always_comb begin
        acc_id    = '0;
        acc_we    = 1'b0;
        acc_lock  = 1'b0;
        acc_addr  = '0;
        acc_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                acc_id    = ID_W'(i);
                acc_we    = req_we[i];
                acc_lock  = req_lock[i];
                acc_addr  = req_addr[i*ADDR_W +: ADDR_W];
                acc_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign accept = |(req & gnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_valid <= 1'b0;
            owner_id    <= '0;
            bram_en     <= 1'b0;
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_di     <= '0;
            for (int i = 0; i <= RD_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            owner_valid <= accept && acc_lock;
            if (accept) begin
                owner_id  <= acc_id;
                bram_addr <= acc_addr;
                bram_di   <= acc_wdata;
            end
            bram_en     <= accept;
            bram_we     <= accept && acc_we;
            tag_pipe[0] <= '{valid: accept, rd: accept && !acc_we, id: acc_id};
            for (int i = 1; i <= RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tag_out = tag_pipe[RD_LAT];

    always_comb begin
        rd_valid = '0;
        if (tag_out.valid && tag_out.rd) rd_valid[tag_out.id] = 1'b1;
    end

    assign rd_data = (tag_out.valid && tag_out.rd) ? bram_dout : '0;

endmodule

// File: tb/tb_ts_bram_port_arbiter.sv
// Directed self-checking bench for ts_bram_port_arbiter with a write-first BRAM model
// and a due-cycle scoreboard for returned reads.
module tb_ts_bram_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 12;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req, req_lock, req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    gnt, rd_valid;
    logic [DW-1:0]    rd_data;
    logic             bram_en, bram_we;
    logic [AW-1:0]    bram_addr;
    logic [DW-1:0]    bram_di;
    logic [DW-1:0]    bram_dout;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t     sb[$];
    exp_t     mon_e;
    int       n_assert = 0;
    int       n_fail   = 0;
    int       cyc      = 0;
    int       cnt[NR];
    logic     preload;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    ts_bram_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_lock  (req_lock),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_di   (bram_di),
        .bram_dout (bram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 'h010) return 8'h11;
        if (a == 'h020) return 8'h22;
        if (a == 'h030) return 8'h33;
        if (a == 'h040) return 8'h44;
        if (a >= 'h050 && a <= 'h090) return DW'(a) ^ 8'hA5;
        return 8'h00;
    endfunction

    // Write-first single-port BRAM, one cycle read latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < (1<<AW); a++) mem[a] <= init_val(a);
            bram_dout <= '0;
        end else if (bram_en) begin
            if (bram_we) begin
                mem[bram_addr] <= bram_di;
                bram_dout      <= bram_di;
            end else begin
                bram_dout <= mem[bram_addr];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            chk("rd_valid", 32'(rd_valid), 32'(1) << mon_e.id);
            chk("rd_data", 32'(rd_data), 32'(mon_e.data));
        end else begin
            chk("rd_valid_idle", 32'(rd_valid), 32'h0);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear();
        req       = '0;
        req_lock  = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        req[i]               = 1'b1;
        req_we[i]            = 1'b0;
        req_addr[i*AW +: AW] = a;
    endtask

    task automatic push(input int id, input logic [DW-1:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        e.due  = cyc + 2;
        sb.push_back(e);
    endtask

    initial begin
        rst     = 1'b1;
        preload = 1'b1;
        clear();
        repeat (3) @(posedge clk);
        #1 preload = 1'b0;
        mid();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_bram_en", 32'(bram_en), 0);
        chk("rst_bram_addr", 32'(bram_addr), 0);
        next();
        rst = 1'b0;

        // Fixed priority between requesters 1 and 3.
        next(); clear();
        set_rd(1, 12'h010); set_rd(3, 12'h020);
        mid(); chk("prio_gnt1", 32'(gnt), 32'b0010); push(1, 8'h11);
        next(); req[1] = 1'b0;
        mid(); chk("prio_gnt3", 32'(gnt), 32'b1000); push(3, 8'h22);
        next(); clear();
        repeat (3) next();

        // Write then read the same address on consecutive accepts.
        next(); clear();
        req[0] = 1'b1; req_we[0] = 1'b1;
        req_addr[0 +: AW] = 12'h123; req_wdata[0 +: DW] = 8'h7F;
        mid(); chk("wr_gnt", 32'(gnt), 32'b0001);
        next(); clear(); set_rd(1, 12'h123);
        mid(); chk("rd_gnt", 32'(gnt), 32'b0010);
        chk("wr_bram_en", 32'(bram_en), 1);
        chk("wr_bram_we", 32'(bram_we), 1);
        chk("wr_bram_addr", 32'(bram_addr), 32'h123);
        chk("wr_bram_di", 32'(bram_di), 32'h7F);
        push(1, 8'h7F);
        next(); clear();
        mid(); chk("rd_bram_en", 32'(bram_en), 1);
        chk("rd_bram_we", 32'(bram_we), 0);
        repeat (3) next();

        // Locked 65-read sweep by requester 2 while requester 0 waits.
        for (int k = 0; k < 65; k++) begin
            next(); clear();
            set_rd(2, AW'(12'h050 + k)); req_lock[2] = 1'b1;
            if (k > 0) set_rd(0, 12'h010);
            mid(); chk("lock_gnt", 32'(gnt), 32'b0100);
            push(2, init_val('h050 + k));
        end
        next(); clear(); set_rd(0, 12'h010);
        mid(); chk("lock_release_gnt", 32'(gnt), 32'b0001); push(0, 8'h11);
        next(); clear();
        repeat (3) next();

        // Idle: no accesses.
        for (int k = 0; k < 10; k++) begin
            next();
            mid(); chk("idle_bram_en", 32'(bram_en), 0);
            chk("idle_gnt", 32'(gnt), 0);
        end

        // Reset in the middle of a read: result must be dropped.
        next(); clear(); set_rd(1, 12'h020);
        mid(); chk("rstmid_gnt", 32'(gnt), 32'b0010);
        next(); clear(); rst = 1'b1;
        mid();
        chk("rstmid_gnt0", 32'(gnt), 0);
        chk("rstmid_rd_data", 32'(rd_data), 0);
        chk("rstmid_bram_en", 32'(bram_en), 0);
        chk("rstmid_bram_we", 32'(bram_we), 0);
        chk("rstmid_bram_addr", 32'(bram_addr), 0);
        chk("rstmid_bram_di", 32'(bram_di), 0);
        next(); rst = 1'b0;
        repeat (3) next();

        // All four requesters held for 8 cycles.
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        for (int k = 0; k < 8; k++) begin
            int eid;
            next(); clear();
            for (int i = 0; i < NR; i++) set_rd(i, AW'(12'h010 + i * 'h10));
`ifdef TS_ARB_ROUND_ROBIN_EN
            eid = k % NR;
`else
            eid = 0;
`endif
            mid(); chk("all_gnt", 32'(gnt), 32'(1) << eid);
            for (int i = 0; i < NR; i++) cnt[i] += int'(gnt[i]);
            push(eid, init_val('h010 + eid * 'h10));
        end
        next(); clear();
        for (int i = 0; i < NR; i++) begin
`ifdef TS_ARB_ROUND_ROBIN_EN
            chk("all_cnt", 32'(cnt[i]), 2);
`else
            chk("all_cnt", 32'(cnt[i]), (i == 0) ? 8 : 0);
`endif
        end
        repeat (4) next();
        mid();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
